// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-FF synchroniser, glitch-rejecting start detection, framing
// check and a valid/ready receive FIFO. Define UART_RX_PARITY_EN to add a parity bit.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    input  logic                        rx_enable,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        overrun,
    output logic                        parity_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT   = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic             PAR_SENSE  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state, state_next;
    logic                 rx_meta, rs;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 bit_tick;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 push, frame_err_next;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic                 fifo_full, do_pop, do_push;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bad, parity_err_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rs      <= 1'b1;
        end else begin
            rx_meta <= rx;
            rs      <= rx_meta;
        end
    end

    assign bit_tick = (bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (rx_enable && !rs) state_next = START;
            START:     if (bit_cnt == HALF_BIT) state_next = rs ? IDLE : DATA;
            DATA: begin
                if (bit_tick && bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY:    if (bit_tick) state_next = STOP;
`endif
            STOP:      if (bit_tick) state_next = rs ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rs) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Stop-bit verdict: a low stop bit always discards, a parity miss discards too.
    always_comb begin
        push           = 1'b0;
        frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_next = 1'b0;
`endif
        if (state == STOP && bit_tick) begin
            if (!rs) begin
                frame_err_next = 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_next = parity_bad;
            end else if (parity_bad) begin
                parity_err_next = 1'b1;
`endif
            end else begin
                push = 1'b1;
            end
        end
    end

    // The bit counter restarts on every state change so each phase is timed from its entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (state_next != state || bit_tick) bit_cnt <= '0;
            else                                 bit_cnt <= bit_cnt + CNT_W'(1);
            if (state == START) bit_idx <= '0;
            if (state == DATA && bit_tick) begin
                shift_reg <= {rs, shift_reg[DATA_BITS-1:1]};
                bit_idx   <= bit_idx + IDX_W'(1);
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)                            parity_bad <= 1'b0;
        else if (state == START)            parity_bad <= 1'b0;
        else if (state == PARITY && bit_tick) parity_bad <= (rs != ((^shift_reg) ^ PAR_SENSE));
    end
`else
    logic unused_parity_sense;
    assign unused_parity_sense = PAR_SENSE;
    assign parity_err          = 1'b0;
`endif

    assign fifo_full = (fifo_count == FULL_COUNT);
    assign rx_valid  = (fifo_count != '0);
    assign do_pop    = rx_ready && rx_valid;
    assign do_push   = push && (!fifo_full || do_pop);
    assign rx_data   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= shift_reg;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      fifo_count <= fifo_count + (PTR_W + 1)'(1);
            else if (do_pop && !do_push) fifo_count <= fifo_count - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= frame_err_next;
            overrun   <= push && fifo_full && !do_pop;
`ifdef UART_RX_PARITY_EN
            parity_err <= parity_err_next;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CLKS_PER_BIT=16, DATA_BITS=8, FIFO_DEPTH=4;
// the parity scenario is built only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_enable = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       frame_err, overrun, parity_err;

    int checks = 0;
    int failures = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int pe_seen = 0;
    int pe_total = 0;
`ifdef UART_RX_PARITY_EN
    logic tx_par_bit = 1'b0;
`endif

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(8),
        .FIFO_DEPTH(4),
        .PARITY_ODD(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_enable(rx_enable),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .fifo_count(fifo_count),
        .frame_err(frame_err),
        .overrun(overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle; a stuck pulse shows up as more than one.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_seen++;
        if (overrun === 1'b1) ov_seen++;
        if (parity_err === 1'b1) begin
            pe_seen++;
            pe_total++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic clear_pulses();
        fe_seen = 0;
        ov_seen = 0;
        pe_seen = 0;
    endtask

    // One frame, LSB first; ready_pulse raises rx_ready for the cycle of the stop sample.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic ready_pulse);
        rx = 1'b0;
        tick(CPB);
        for (int b = 0; b < 8; b++) begin
            rx = data[b];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = tx_par_bit;
        tick(CPB);
`endif
        rx = stop_bit;
        tick(10);
        if (ready_pulse) rx_ready = 1'b1;
        tick(1);
        if (ready_pulse) rx_ready = 1'b0;
        tick(5);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b want=0", rx_valid); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d want=0", fifo_count); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h want=00", rx_data); end
        checks++; if ({frame_err, overrun, parity_err} !== 3'b000) begin failures++; $display("[TB] FAIL reset_pulses got=%b want=000", {frame_err, overrun, parity_err}); end
    endtask

    task automatic test_single_frame();
        clear_pulses();
        rx_ready = 1'b0;
        send_frame(8'h41, 1'b1, 1'b0);
        checks++; if (rx_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_valid got=%b want=1", rx_valid); end
        checks++; if (rx_data !== 8'h41) begin failures++; $display("[TB] FAIL single_data got=%h want=41", rx_data); end
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("[TB] FAIL single_count got=%0d want=1", fifo_count); end
        pop_one();
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_pop_valid got=%b want=0", rx_valid); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL single_pop_count got=%0d want=0", fifo_count); end
        checks++; if (fe_seen !== 0) begin failures++; $display("[TB] FAIL single_frame_err got=%0d want=0", fe_seen); end
    endtask

    task automatic test_glitch();
        clear_pulses();
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL glitch_count got=%0d want=0", fifo_count); end
        checks++; if (fe_seen !== 0) begin failures++; $display("[TB] FAIL glitch_frame_err got=%0d want=0", fe_seen); end
        send_frame(8'h5A, 1'b1, 1'b0);
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("[TB] FAIL glitch_next_count got=%0d want=1", fifo_count); end
        checks++; if (rx_data !== 8'h5A) begin failures++; $display("[TB] FAIL glitch_next_data got=%h want=5a", rx_data); end
        pop_one();
    endtask

    task automatic test_frame_error();
        clear_pulses();
        send_frame(8'h55, 1'b0, 1'b0);
        tick(40);
        checks++; if (fe_seen !== 1) begin failures++; $display("[TB] FAIL ferr_pulses got=%0d want=1", fe_seen); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL ferr_count got=%0d want=0", fifo_count); end
        rx = 1'b1;
        tick(20);
        checks++; if (fe_seen !== 1) begin failures++; $display("[TB] FAIL ferr_break_pulses got=%0d want=1", fe_seen); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL ferr_break_count got=%0d want=0", fifo_count); end
        send_frame(8'h33, 1'b1, 1'b0);
        checks++; if (rx_data !== 8'h33) begin failures++; $display("[TB] FAIL ferr_next_data got=%h want=33", rx_data); end
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("[TB] FAIL ferr_next_count got=%0d want=1", fifo_count); end
        pop_one();
    endtask

    task automatic test_overrun();
        logic [7:0] want;
        clear_pulses();
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            tick(2);
        end
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("[TB] FAIL ovr_count got=%0d want=4", fifo_count); end
        checks++; if (ov_seen !== 1) begin failures++; $display("[TB] FAIL ovr_pulses got=%0d want=1", ov_seen); end
        for (int i = 1; i <= 4; i++) begin
            want = 8'(i);
            checks++; if (rx_data !== want) begin failures++; $display("[TB] FAIL ovr_order got=%h want=%h", rx_data, want); end
            pop_one();
        end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL ovr_drain got=%0d want=0", fifo_count); end

        clear_pulses();
        for (int i = 1; i <= 4; i++) begin
            send_frame(8'(i), 1'b1, 1'b0);
            tick(2);
        end
        send_frame(8'h05, 1'b1, 1'b1);
        checks++; if (ov_seen !== 0) begin failures++; $display("[TB] FAIL full_pushpop_pulses got=%0d want=0", ov_seen); end
        checks++; if (fifo_count !== 3'd4) begin failures++; $display("[TB] FAIL full_pushpop_count got=%0d want=4", fifo_count); end
        for (int i = 2; i <= 5; i++) begin
            want = 8'(i);
            checks++; if (rx_data !== want) begin failures++; $display("[TB] FAIL full_pushpop_order got=%h want=%h", rx_data, want); end
            pop_one();
        end
        pop_one();
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL empty_pop_count got=%0d want=0", fifo_count); end
    endtask

    task automatic test_enable();
        rx_enable = 1'b0;
        send_frame(8'h77, 1'b1, 1'b0);
        tick(4);
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL disabled_count got=%0d want=0", fifo_count); end
        rx_enable = 1'b1;
        tick(4);
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h11, 1'b1, 1'b0);
        clear_pulses();
        rx = 1'b0;
        tick(CPB);
        rx = 1'b1;
        tick(3 * CPB);
        do_reset();
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL midrst_count got=%0d want=0", fifo_count); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid got=%b want=0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL midrst_data got=%h want=00", rx_data); end
        tick(30);
        checks++; if (fe_seen + ov_seen + pe_seen !== 0) begin failures++; $display("[TB] FAIL midrst_pulses got=%0d want=0", fe_seen + ov_seen + pe_seen); end
        send_frame(8'hA5, 1'b1, 1'b0);
        checks++; if (rx_data !== 8'hA5) begin failures++; $display("[TB] FAIL midrst_next_data got=%h want=a5", rx_data); end
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("[TB] FAIL midrst_next_count got=%0d want=1", fifo_count); end
        pop_one();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        clear_pulses();
        tx_par_bit = 1'b1;
        send_frame(8'h41, 1'b1, 1'b0);
        checks++; if (pe_seen !== 1) begin failures++; $display("[TB] FAIL parity_bad_pulses got=%0d want=1", pe_seen); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("[TB] FAIL parity_bad_count got=%0d want=0", fifo_count); end
        clear_pulses();
        tx_par_bit = 1'b0;
        send_frame(8'h41, 1'b1, 1'b0);
        checks++; if (pe_seen !== 0) begin failures++; $display("[TB] FAIL parity_ok_pulses got=%0d want=0", pe_seen); end
        checks++; if (rx_data !== 8'h41) begin failures++; $display("[TB] FAIL parity_ok_data got=%h want=41", rx_data); end
        pop_one();
    endtask
`else
    task automatic test_parity();
        checks++; if (pe_total !== 0) begin failures++; $display("[TB] FAIL parity_tied got=%0d want=0", pe_total); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_enable();
        test_reset_mid_frame();
        test_parity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
